dmem_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer in front of the single-port data memory.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory (IDLE -> ACCESS -> RESP).
// Optional range/alignment checking is enabled by defining DMEM_ARB_ERR_EN.
module dmem_arbiter #(
   parameter int unsigned MEM_WORDS  = 256,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [2:0]  m0_type,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [2:0]  m1_type,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        mem_W_en,
   output logic        mem_R_en,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_RW_type,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   logic        last_gnt;
   logic        sel;
   logic        we_q;
   logic        err_q;

   logic        pick;
   logic        req_any;
   logic        cand_we;
   logic [31:0] cand_addr;
   logic [2:0]  cand_type;
   logic [31:0] cand_wdata;
   logic        cand_err;
   logic [31:0] resp_data;

   if (MEM_WORDS < 1 || MEM_WORDS > 32'h4000_0000) begin : g_bad_mem_words
      $error("dmem_arbiter: MEM_WORDS out of range");
   end

`ifdef DMEM_ARB_ERR_EN
   function automatic logic access_err(input logic [31:0] a, input logic [2:0] t);
      logic e;
      e = 1'b0;
      case (t)
         3'b000, 3'b100: e = 1'b0;
         3'b001, 3'b101: e = a[0];
         3'b010:         e = |a[1:0];
         default:        e = 1'b1;
      endcase
      if ({2'b00, a[31:2]} >= 32'(MEM_WORDS)) e = 1'b1;
      return e;
   endfunction
`endif

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      req_any = m0_req | m1_req;
      pick    = 1'b0;
      if (m0_req && m1_req) pick = FIXED_PRIO ? 1'b0 : ~last_gnt;
      else if (m1_req)      pick = 1'b1;

      cand_we    = pick ? m1_we    : m0_we;
      cand_addr  = pick ? m1_addr  : m0_addr;
      cand_type  = pick ? m1_type  : m0_type;
      cand_wdata = pick ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_ERR_EN
      cand_err   = access_err(cand_addr, cand_type);
`else
      cand_err   = 1'b0;
`endif
      resp_data  = (we_q || err_q) ? 32'h0 : mem_dout;
   end

   // NOTE: sequential state uses non-blocking assignments only; reset clears every output at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_gnt    <= 1'b1;
         sel         <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         m0_gnt      <= 1'b0;
         m1_gnt      <= 1'b0;
         m0_rvalid   <= 1'b0;
         m1_rvalid   <= 1'b0;
         m0_rdata    <= 32'h0;
         m1_rdata    <= 32'h0;
         m0_err      <= 1'b0;
         m1_err      <= 1'b0;
         mem_W_en    <= 1'b0;
         mem_R_en    <= 1'b0;
         mem_addr    <= 32'h0;
         mem_RW_type <= 3'b000;
         mem_din     <= 32'h0;
      end else begin
         // Pulse outputs default low; the active state raises them for one cycle.
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= 32'h0;
         m1_rdata  <= 32'h0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
         mem_W_en  <= 1'b0;
         mem_R_en  <= 1'b0;

         case (state)
            IDLE: begin
               if (req_any) begin
                  sel         <= pick;
                  last_gnt    <= pick;
                  we_q        <= cand_we;
                  err_q       <= cand_err;
                  mem_addr    <= cand_addr;
                  mem_RW_type <= cand_type;
                  mem_din     <= cand_wdata;
                  mem_W_en    <= cand_we & ~cand_err;
                  mem_R_en    <= ~cand_we & ~cand_err;
                  m0_gnt      <= ~pick;
                  m1_gnt      <= pick;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (sel) begin
                  m1_rvalid <= 1'b1;
                  m1_rdata  <= resp_data;
                  m1_err    <= err_q;
               end else begin
                  m0_rvalid <= 1'b1;
                  m0_rdata  <= resp_data;
                  m0_err    <= err_q;
               end
               state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of single accesses plus arbitration,
// reset-in-ACCESS and late-request sequences. Expectations follow DMEM_ARB_ERR_EN.
module tb_dmem_arbiter;

   localparam bit FIXED_PRIO = 1'b0;
`ifdef DMEM_ARB_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req = 0, m0_we = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0;
   logic [2:0]  m0_type = 0;
   logic        m1_req = 0, m1_we = 0;
   logic [31:0] m1_addr = 0, m1_wdata = 0;
   logic [2:0]  m1_type = 0;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_W_en, mem_R_en;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic [2:0]  mem_RW_type;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:255];

   dmem_arbiter #(.MEM_WORDS(256), .FIXED_PRIO(FIXED_PRIO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_type(m0_type), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_type(m1_type), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
      .mem_RW_type(mem_RW_type), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Behavioural memory: sized/extending loads, byte-lane stores, aliasing on addr[9:2].
   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] t);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = w[{a[1], 4'b0000} +: 16];
      case (t)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] a,
                                         input logic [2:0] t, input logic [31:0] d);
      logic [31:0] r;
      r = old;
      case (t[1:0])
         2'b00:   r[{a, 3'b000} +: 8]     = d[7:0];
         2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
         default: r = d;
      endcase
      return r;
   endfunction

   always_comb mem_dout = load_val(mem[mem_addr[9:2]], mem_addr[1:0], mem_RW_type);

   always @(posedge clk)
      if (mem_W_en) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_addr[1:0], mem_RW_type, mem_din);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One-hot grant and response at every sampling point.
   always @(negedge clk) begin
      check("gnt_onehot",    32'(m0_gnt & m1_gnt), 32'h0);
      check("rvalid_onehot", 32'(m0_rvalid & m1_rvalid), 32'h0);
   end

   task automatic drive(input bit p, input bit req, input bit we, input logic [31:0] addr,
                        input logic [2:0] typ, input logic [31:0] wdata);
      if (p) begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_type = typ; m1_wdata = wdata;
      end else begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_type = typ; m0_wdata = wdata;
      end
   endtask

   typedef struct {
      string       name;
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [2:0]  typ;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   task automatic run_access(input vec_t v);
      int cyc;
      @(negedge clk);
      drive(v.port, 1'b1, v.we, v.addr, v.typ, v.wdata);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(v.port ? m1_gnt : m0_gnt) && cyc < 8);
      check({v.name, "_gnt_latency"}, cyc, 1);
      check({v.name, "_wen"},  32'(mem_W_en), 32'(v.we && !v.exp_err));
      check({v.name, "_ren"},  32'(mem_R_en), 32'(!v.we && !v.exp_err));
      check({v.name, "_addr"}, mem_addr, v.addr);
      drive(v.port, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      check({v.name, "_rvalid"}, 32'(v.port ? m1_rvalid : m0_rvalid), 32'h1);
      check({v.name, "_rdata"},  v.port ? m1_rdata : m0_rdata, v.exp_rdata);
      check({v.name, "_err"},    32'(v.port ? m1_err : m0_err), 32'(v.exp_err));
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t vecs[18];

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      bit winner;
      foreach (mem[i]) mem[i] = 32'h0;

      vecs[0]  = '{"sw10",    0, 1, 32'h10,  3'b010, 32'hDEADBEEF, 32'h0, 0};
      vecs[1]  = '{"lw10",    0, 0, 32'h10,  3'b010, 32'h0, 32'hDEADBEEF, 0};
      vecs[2]  = '{"m1sw10",  1, 1, 32'h10,  3'b010, 32'h11223344, 32'h0, 0};
      vecs[3]  = '{"m1sb13",  1, 1, 32'h13,  3'b000, 32'h000000AA, 32'h0, 0};
      vecs[4]  = '{"m1lbu13", 1, 0, 32'h13,  3'b100, 32'h0, 32'h000000AA, 0};
      vecs[5]  = '{"m1lw10",  1, 0, 32'h10,  3'b010, 32'h0, 32'hAA223344, 0};
      vecs[6]  = '{"lb13",    0, 0, 32'h13,  3'b000, 32'h0, 32'hFFFFFFAA, 0};
      vecs[7]  = '{"sh22",    0, 1, 32'h22,  3'b001, 32'h0000BEEF, 32'h0, 0};
      vecs[8]  = '{"lhu22",   0, 0, 32'h22,  3'b101, 32'h0, 32'h0000BEEF, 0};
      vecs[9]  = '{"lh22",    1, 0, 32'h22,  3'b001, 32'h0, 32'hFFFFBEEF, 0};
      vecs[10] = '{"lw20",    0, 0, 32'h20,  3'b010, 32'h0, 32'hBEEF0000, 0};
      vecs[11] = '{"sw3fc",   1, 1, 32'h3FC, 3'b010, 32'hCAFEF00D, 32'h0, 0};
      vecs[12] = '{"lw3fc",   0, 0, 32'h3FC, 3'b010, 32'h0, 32'hCAFEF00D, 0};
      vecs[13] = '{"lw_mis2", 0, 0, 32'h2,   3'b010, 32'h0, 32'h0, ERR_ON};
      vecs[14] = '{"sw400",   0, 1, 32'h400, 3'b010, 32'h12345678, 32'h0, ERR_ON};
      vecs[15] = '{"lw0",     0, 0, 32'h0,   3'b010, 32'h0, ERR_ON ? 32'h0 : 32'h12345678, 0};
      vecs[16] = '{"lh_mis21",1, 0, 32'h21,  3'b001, 32'h0, 32'h0, ERR_ON};
      vecs[17] = '{"ld_t011", 1, 0, 32'h10,  3'b011, 32'h0, ERR_ON ? 32'h0 : 32'hAA223344, ERR_ON};

      // Reset state: outputs low while reset is held.
      #2;
      check("rst_m0_gnt",   32'(m0_gnt), 0);
      check("rst_m1_rvalid",32'(m1_rvalid), 0);
      check("rst_mem_wen",  32'(mem_W_en | mem_R_en), 0);
      check("rst_mem_addr", mem_addr, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_no_gnt", 32'(m0_gnt | m1_gnt), 0);

      foreach (vecs[i]) run_access(vecs[i]);

      // Tie: both hold requests for four accesses; m0 wins first after reset.
      do_reset();
      drive(0, 1'b1, 1'b0, 32'h10,  3'b010, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h3FC, 3'b010, 32'h0);
      for (int k = 0; k < 4; k++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!(m0_gnt || m1_gnt) && cyc < 8);
         winner = m1_gnt;
         check($sformatf("tie_gnt%0d_seen", k), 32'(m0_gnt | m1_gnt), 1);
         check($sformatf("tie_winner%0d", k), 32'(winner), FIXED_PRIO ? 0 : 32'(k % 2));
         @(negedge clk);
         check($sformatf("tie_rvalid%0d", k), 32'(winner ? m1_rvalid : m0_rvalid), 1);
         check($sformatf("tie_rdata%0d", k), winner ? m1_rdata : m0_rdata,
               winner ? 32'hCAFEF00D : 32'hAA223344);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      @(negedge clk);

      // Reset asserted during ACCESS of a store: store must not commit.
      run_access('{"sw20_5", 0, 1, 32'h20, 3'b010, 32'h5, 32'h0, 0});
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h20, 3'b010, 32'h77);
      @(negedge clk);
      check("rst_acc_gnt", 32'(m0_gnt), 1);
      check("rst_acc_wen_before", 32'(mem_W_en), 1);
      rst_n = 1'b0;
      #1;
      check("rst_acc_wen_after", 32'(mem_W_en), 0);
      check("rst_acc_gnt_after", 32'(m0_gnt), 0);
      check("rst_acc_addr_after", mem_addr, 0);
      drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      check("rst_acc_no_rvalid", 32'(m0_rvalid), 0);
      check("rst_acc_mem_word", mem[8], 32'h5);
      rst_n = 1'b1;
      run_access('{"lw20_after_rst", 0, 0, 32'h20, 3'b010, 32'h0, 32'h5, 0});

      // m1 raises req during m0 ACCESS and holds through RESP.
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0);
      @(negedge clk);
      check("late_m0_gnt", 32'(m0_gnt), 1);
      drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h3FC, 3'b010, 32'h0);
      @(negedge clk);
      check("late_m0_rvalid", 32'(m0_rvalid), 1);
      check("late_m1_wait_resp", 32'(m1_gnt), 0);
      @(negedge clk);
      check("late_m1_wait_idle", 32'(m1_gnt), 0);
      @(negedge clk);
      check("late_m1_gnt", 32'(m1_gnt), 1);
      drive(1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      check("late_m1_rvalid", 32'(m1_rvalid), 1);
      check("late_m1_rdata", m1_rdata, 32'hCAFEF00D);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
